// File: rtl/hazard_stall_controller_if.sv
// Signal bundle between the ID/EX pipeline logic and the hazard/stall sequencer.
// The master side supplies decode/EX status; the slave side returns pipeline enables.
interface hazard_stall_controller_if;
  logic [4:0]  ID_Rs;
  logic [4:0]  ID_Rt;
  logic        ID_UsesRt;
  logic        ID_IsMul;
  logic        EX_MemRead;
  logic [4:0]  EX_Rt;
  logic        EX_BranchTaken;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        IFIDFlush;
  logic        IDEXBubble;
  logic        IDEXHold;
  logic        MulBusy;
  logic [15:0] StallCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_IsMul, EX_MemRead, EX_Rt, EX_BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXHold, MulBusy, StallCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_IsMul, EX_MemRead, EX_Rt, EX_BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, IDEXHold, MulBusy, StallCount
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencer for the 5-stage core: load-use stalls, taken-branch
// flushes, multi-cycle MUL occupancy of EX, and a saturating stall-cycle counter.
module hazard_stall_controller #(
  parameter int MUL_LAT = 4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  hazard_stall_controller_if.slave  bus
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MUL_WAIT = 1'b1
  } state_t;

  localparam logic [3:0] MUL_INIT  = 4'(MUL_LAT - 1);
  localparam logic       MUL_MULTI = (MUL_LAT > 1) ? 1'b1 : 1'b0;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic [15:0] stall_cnt_r;

  logic        load_use_s;
  logic        pc_write_s;
  logic        ifid_write_s;
  logic        ifid_flush_s;
  logic        idex_bubble_s;
  logic        idex_hold_s;
  logic        mul_busy_s;

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    load_use_s = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
                 ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));
  end

  // Next-state and control outputs; reset forces a flush/bubble with the front end frozen.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    pc_write_s    = 1'b0;
    ifid_write_s  = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    idex_hold_s   = 1'b0;
    mul_busy_s    = 1'b0;
    if (Rst) begin
      state_nxt_s   = RUN;
      cnt_nxt_s     = 4'd0;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (bus.EX_BranchTaken) begin
            pc_write_s    = 1'b1;
            ifid_write_s  = 1'b1;
            ifid_flush_s  = 1'b1;
            idex_bubble_s = 1'b1;
          end else if (load_use_s) begin
            idex_bubble_s = 1'b1;
          end else if (bus.ID_IsMul && MUL_MULTI) begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
            state_nxt_s  = MUL_WAIT;
            cnt_nxt_s    = MUL_INIT;
          end else begin
            pc_write_s   = 1'b1;
            ifid_write_s = 1'b1;
          end
        end
        MUL_WAIT: begin
          idex_hold_s = 1'b1;
          mul_busy_s  = 1'b1;
          // A zero count can only come from corruption; fall back to RUN rather than wrap.
          if (cnt_r <= 4'd1) begin
            state_nxt_s = RUN;
            cnt_nxt_s   = 4'd0;
          end else begin
            state_nxt_s = MUL_WAIT;
            cnt_nxt_s   = cnt_r - 4'd1;
          end
        end
        default: begin
          state_nxt_s   = RUN;
          cnt_nxt_s     = 4'd0;
          idex_bubble_s = 1'b1;
        end
      endcase
    end
  end

  // FSM state and MUL countdown registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stall_cnt_r <= 16'd0;
    end else if (!pc_write_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.PCWrite    = pc_write_s;
  assign bus.IFIDWrite  = ifid_write_s;
  assign bus.IFIDFlush  = ifid_flush_s;
  assign bus.IDEXBubble = idex_bubble_s;
  assign bus.IDEXHold   = idex_hold_s;
  assign bus.MulBusy    = mul_busy_s;
  assign bus.StallCount = stall_cnt_r;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller (MUL_LAT = 4): a per-cycle vector
// table fed through a scoreboard queue, then a long stall run for counter saturation.
module tb_hazard_stall_controller;

  logic Clk;
  logic Rst;
  int   errors;
  int   checks;

  hazard_stall_controller_if hsc_bus ();

  hazard_stall_controller #(.MUL_LAT(4)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (hsc_bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic        rst;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses;
    logic        mul;
    logic        mrd;
    logic [4:0]  ert;
    logic        br;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        bub;
    logic        hold;
    logic        busy;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl [29];
  vec_t sb_q [$];

  function automatic vec_t mk(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                              input logic uses, input logic mul, input logic mrd,
                              input logic [4:0] ert, input logic br,
                              input logic pcw, input logic ifw, input logic fl,
                              input logic bub, input logic hold, input logic busy,
                              input logic [15:0] sc);
    vec_t v;
    v.rst = r;   v.rs = rs;   v.rt = rt;   v.uses = uses; v.mul = mul;
    v.mrd = mrd; v.ert = ert; v.br = br;
    v.pcw = pcw; v.ifw = ifw; v.fl = fl;   v.bub = bub;   v.hold = hold;
    v.busy = busy; v.sc = sc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Rst                    = v.rst;
    hsc_bus.ID_Rs          = v.rs;
    hsc_bus.ID_Rt          = v.rt;
    hsc_bus.ID_UsesRt      = v.uses;
    hsc_bus.ID_IsMul       = v.mul;
    hsc_bus.EX_MemRead     = v.mrd;
    hsc_bus.EX_Rt          = v.ert;
    hsc_bus.EX_BranchTaken = v.br;
  endtask

  task automatic compare(input int idx);
    vec_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard [%0d]: actual=empty expected=entry", idx);
    end else begin
      e = sb_q.pop_front();
      chk("PCWrite",    idx, 16'(hsc_bus.PCWrite),    16'(e.pcw));
      chk("IFIDWrite",  idx, 16'(hsc_bus.IFIDWrite),  16'(e.ifw));
      chk("IFIDFlush",  idx, 16'(hsc_bus.IFIDFlush),  16'(e.fl));
      chk("IDEXBubble", idx, 16'(hsc_bus.IDEXBubble), 16'(e.bub));
      chk("IDEXHold",   idx, 16'(hsc_bus.IDEXHold),   16'(e.hold));
      chk("MulBusy",    idx, 16'(hsc_bus.MulBusy),    16'(e.busy));
      chk("StallCount", idx, hsc_bus.StallCount,      e.sc);
    end
  endtask

  initial begin
    vec_t lu;
    errors = 0;
    checks = 0;
    //            rst rs     rt     us   mul  mrd  ert    br   pcw  ifw  fl   bub  hld  bsy  sc
    tbl[0]  = mk(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    tbl[1]  = mk(1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    tbl[2]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    tbl[3]  = mk(1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    tbl[4]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    tbl[5]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    tbl[6]  = mk(1'b0, 5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    tbl[7]  = mk(1'b0, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    tbl[8]  = mk(1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd2);
    tbl[9]  = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    tbl[10] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    tbl[11] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd2);
    tbl[12] = mk(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd3);
    tbl[13] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd4);
    tbl[14] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    tbl[15] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);
    tbl[16] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd5);
    tbl[17] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd6);
    tbl[18] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd7);
    tbl[19] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd8);
    tbl[20] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd8);
    tbl[21] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd9);
    tbl[22] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd10);
    tbl[23] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd11);
    tbl[24] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd11);
    tbl[25] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd11);
    tbl[26] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'd12);
    tbl[27] = mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    tbl[28] = mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

    drive(tbl[0]);
    @(posedge Clk);
    #1;
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i]);
      sb_q.push_back(tbl[i]);
      @(negedge Clk);
      compare(i);
      @(posedge Clk);
      #1;
    end

    // Continuous load-use stall: counter must climb to 16'hFFFF and stay there.
    lu = mk(1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    drive(lu);
    for (int i = 0; i < 70000; i++) begin
      @(negedge Clk);
      if (i == 0 || i == 65534 || i == 65535 || i == 69999) begin
        chk("SatPCWrite", i, 16'(hsc_bus.PCWrite), 16'd0);
        chk("SatCount", i, hsc_bus.StallCount,
            (i >= 65535) ? 16'hFFFF : 16'(i));
      end
      @(posedge Clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
